// File: rtl/rf_scoreboard_pkg.sv
// Shared scoreboard definitions: register-number width, register count and
// the RUN/DRAIN state encoding used by rf_scoreboard and its hazard checker.
package rf_scoreboard_pkg;

  localparam int SB_REG_NUM_W = 5;
  localparam int SB_NUM_REGS  = 32;

  typedef enum logic {SB_RUN, SB_DRAIN} sb_state_t;

endpackage

// File: rtl/sb_hazard_check.sv
// Purely combinational RAW/WAW hazard detection against the effective busy
// vector. Register x0 never produces a hazard.
module sb_hazard_check
  import rf_scoreboard_pkg::*;
(
  input  logic [SB_NUM_REGS-1:0]  busy_eff_i,
  input  logic [SB_REG_NUM_W-1:0] rs1_i,
  input  logic                    rs1_used_i,
  input  logic [SB_REG_NUM_W-1:0] rs2_i,
  input  logic                    rs2_used_i,
  input  logic [SB_REG_NUM_W-1:0] rd_i,
  input  logic                    rd_we_i,
  output logic                    hazard_o
);

  logic raw1;
  logic raw2;
  logic waw;

  // Each operand hazards only when it is actually used and names a busy nonzero register
  always_comb begin
    raw1     = rs1_used_i && (rs1_i != '0) && busy_eff_i[rs1_i];
    raw2     = rs2_used_i && (rs2_i != '0) && busy_eff_i[rs2_i];
    waw      = rd_we_i    && (rd_i  != '0) && busy_eff_i[rd_i];
    hazard_o = raw1 || raw2 || waw;
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file hazard controller: tracks in-flight destination registers,
// stalls decode on RAW/WAW hazards or the in-flight limit, releases registers
// on writeback and drains outstanding writes after a flush.
// Optional build macro SB_WB_BYPASS_EN: when defined, a register being
// written back this cycle is treated as free for issue in the same cycle.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              issue_valid,
  input  logic [SB_REG_NUM_W-1:0]           issue_rs1,
  input  logic                              issue_rs1_used,
  input  logic [SB_REG_NUM_W-1:0]           issue_rs2,
  input  logic                              issue_rs2_used,
  input  logic [SB_REG_NUM_W-1:0]           issue_rd,
  input  logic                              issue_rd_we,
  output logic                              issue_ready,
  input  logic                              wb_valid,
  input  logic [SB_REG_NUM_W-1:0]           wb_rd,
  input  logic                              flush,
  output logic [SB_NUM_REGS-1:0]            busy_vec,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              draining,
  output logic [CNT_W-1:0]                  stall_cnt,
  output logic                              wb_err
);

  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [INF_W-1:0] MAX_INF = INF_W'(MAX_INFLIGHT);

  sb_state_t               state_q, state_d;
  logic [SB_NUM_REGS-1:0]  busy_q, busy_d, busy_eff, wb_mask;
  logic [INF_W-1:0]        inflight_q, inflight_d;
  logic [CNT_W-1:0]        stall_q;
  logic                    wb_err_q;
  logic                    tracked, wb_hit, wb_bad, hazard, fire;

  // Decode the writeback into a one-hot clear mask and classify it
  always_comb begin
    tracked = issue_rd_we && (issue_rd != '0);
    wb_mask = '0;
    if (wb_valid && (wb_rd != '0)) wb_mask[wb_rd] = 1'b1;
    wb_hit  = |(wb_mask & busy_q);
    wb_bad  = wb_valid && (wb_rd != '0) && !busy_q[wb_rd];
  end

`ifdef SB_WB_BYPASS_EN
  // Bypass: a register retiring this cycle no longer blocks issue
  assign busy_eff = busy_q & ~wb_mask;
`else
  // No bypass: issue sees only the registered busy bits
  assign busy_eff = busy_q;
`endif

  sb_hazard_check u_hazard (
    .busy_eff_i (busy_eff),
    .rs1_i      (issue_rs1),
    .rs1_used_i (issue_rs1_used),
    .rs2_i      (issue_rs2),
    .rs2_used_i (issue_rs2_used),
    .rd_i       (issue_rd),
    .rd_we_i    (issue_rd_we),
    .hazard_o   (hazard)
  );

  // Issue acceptance and next busy/inflight values; clear from writeback first, then set from issue
  always_comb begin
    // NOTE: every output gets a default before any condition so no latch is inferred.
    busy_d      = busy_q;
    inflight_d  = inflight_q;
    issue_ready = (state_q == SB_RUN) && !flush && !hazard
                  && !(tracked && (inflight_q == MAX_INF));
    fire        = issue_valid && issue_ready;
    if (wb_hit) begin
      busy_d[wb_rd] = 1'b0;
      inflight_d    = inflight_d - 1'b1;
    end
    if (fire && tracked) begin
      busy_d[issue_rd] = 1'b1;
      inflight_d       = inflight_d + 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Next state: enter DRAIN on flush with writes still outstanding, leave once none remain
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SB_RUN:   if (flush && (inflight_d != '0)) state_d = SB_DRAIN;
      SB_DRAIN: if (inflight_d == '0)            state_d = SB_RUN;
      default:                                   state_d = SB_RUN;
    endcase
  end

  // State registers, saturating stall counter and sticky writeback-error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SB_RUN;
      busy_q     <= '0;
      inflight_q <= '0;
      stall_q    <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      if (issue_valid && !issue_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (wb_bad) wb_err_q <= 1'b1;
    end
  end

  assign busy_vec  = busy_q;
  assign inflight  = inflight_q;
  assign draining  = (state_q == SB_DRAIN);
  assign stall_cnt = stall_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench for rf_scoreboard (MAX_INFLIGHT=4, CNT_W=16).
// Honours SB_WB_BYPASS_EN to pick the expected bypass timing.
module tb_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_rs1_used, issue_rs2_used, issue_rd_we;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic        issue_ready, wb_valid, flush, draining, wb_err;
  logic [31:0] busy_vec;
  logic [2:0]  inflight;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int stall_exp = 0;

  rf_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_rs1      (issue_rs1),
    .issue_rs1_used (issue_rs1_used),
    .issue_rs2      (issue_rs2),
    .issue_rs2_used (issue_rs2_used),
    .issue_rd       (issue_rd),
    .issue_rd_we    (issue_rd_we),
    .issue_ready    (issue_ready),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .flush          (flush),
    .busy_vec       (busy_vec),
    .inflight       (inflight),
    .draining       (draining),
    .stall_cnt      (stall_cnt),
    .wb_err         (wb_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs1_used = 0; issue_rs2 = 0;
    issue_rs2_used = 0; issue_rd = 0; issue_rd_we = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic [4:0] rs1, input logic rs1_u);
    issue_valid = 1; issue_rd = rd; issue_rd_we = we; issue_rs1 = rs1; issue_rs1_used = rs1_u;
    issue_rs2 = 0; issue_rs2_used = 0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #3;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h exp 0", busy_vec); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight: got %0d exp 0", inflight); end
    checks++; if ({draining, wb_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {draining, wb_err}); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d exp 0", stall_cnt); end
    @(negedge clk) rst_n = 1;
    step();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", issue_ready); end
  endtask

  task automatic test_raw();
    issue(5'd5, 1'b1, 5'd0, 1'b0);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_first_ready: got %b exp 1", issue_ready); end
    step();
    checks++; if (busy_vec !== 32'h0000_0020) begin errors++; $display("FAIL raw_busy: got %h exp 00000020", busy_vec); end
    checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL raw_inflight: got %0d exp 1", inflight); end
    issue(5'd0, 1'b0, 5'd5, 1'b1);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_rs1_stall: got %b exp 0", issue_ready); end
    step(); stall_exp++;
    // rs2 dependency must stall just the same
    issue_rs1_used = 0; issue_rs2 = 5'd5; issue_rs2_used = 1; #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_rs2_stall: got %b exp 0", issue_ready); end
    step(); stall_exp++;
    checks++; if (stall_cnt !== 16'(stall_exp)) begin errors++; $display("FAIL raw_stall_cnt: got %0d exp %0d", stall_cnt, stall_exp); end
    wb_valid = 1; wb_rd = 5'd5; #1;
`ifdef SB_WB_BYPASS_EN
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_bypass_ready: got %b exp 1", issue_ready); end
    step();
    wb_valid = 0;
`else
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_nobypass_wbcycle: got %b exp 0", issue_ready); end
    step(); stall_exp++;
    wb_valid = 0; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_nobypass_ready: got %b exp 1", issue_ready); end
    step();
`endif
    idle(); #1;
    checks++; if (busy_vec !== 32'h0 || inflight !== 3'd0) begin errors++; $display("FAIL raw_release: got busy %h inflight %0d exp 0 0", busy_vec, inflight); end
    checks++; if (stall_cnt !== 16'(stall_exp)) begin errors++; $display("FAIL raw_stall_total: got %0d exp %0d", stall_cnt, stall_exp); end
  endtask

  task automatic test_x0();
    for (int i = 0; i < 4; i++) begin
      issue(5'd0, 1'b1, 5'd0, 1'b0);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL x0_ready_%0d: got %b exp 1", i, issue_ready); end
      step();
    end
    idle(); #1;
    checks++; if (busy_vec !== 32'h0 || inflight !== 3'd0) begin errors++; $display("FAIL x0_untracked: got busy %h inflight %0d exp 0 0", busy_vec, inflight); end
  endtask

  task automatic test_limit();
    for (int r = 1; r <= 4; r++) begin
      issue(5'(r), 1'b1, 5'd0, 1'b0);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL limit_fill_%0d: got %b exp 1", r, issue_ready); end
      step();
    end
    checks++; if (inflight !== 3'd4 || busy_vec !== 32'h0000_001E) begin errors++; $display("FAIL limit_full: got inflight %0d busy %h exp 4 0000001e", inflight, busy_vec); end
    issue(5'd6, 1'b1, 5'd0, 1'b0);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL limit_block: got %b exp 0", issue_ready); end
    step(); stall_exp++;
    issue(5'd0, 1'b0, 5'd7, 1'b1);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL limit_nowrite_ok: got %b exp 1", issue_ready); end
    step();
    idle(); wb_valid = 1; wb_rd = 5'd3;
    step();
    // Same-cycle writeback of r4 and issue of r8: inflight stays at 3
    wb_rd = 5'd4; issue(5'd8, 1'b1, 5'd0, 1'b0);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL limit_fire_wb_ready: got %b exp 1", issue_ready); end
    step();
    checks++; if (inflight !== 3'd3 || busy_vec !== 32'h0000_0106) begin errors++; $display("FAIL limit_fire_wb: got inflight %0d busy %h exp 3 00000106", inflight, busy_vec); end
    idle(); wb_valid = 1; wb_rd = 5'd8;
    step();
    idle(); #1;
    checks++; if (inflight !== 3'd2 || busy_vec !== 32'h0000_0006) begin errors++; $display("FAIL limit_wb8: got inflight %0d busy %h exp 2 00000006", inflight, busy_vec); end
    checks++; if (stall_cnt !== 16'(stall_exp)) begin errors++; $display("FAIL limit_stall_cnt: got %0d exp %0d", stall_cnt, stall_exp); end
  endtask

  task automatic test_flush();
    flush = 1; #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_block: got %b exp 0", issue_ready); end
    step();
    flush = 0; #1;
    checks++; if (draining !== 1'b1 || issue_ready !== 1'b0) begin errors++; $display("FAIL flush_drain: got draining %b ready %b exp 1 0", draining, issue_ready); end
    wb_valid = 1; wb_rd = 5'd1; flush = 1;
    step();
    checks++; if (draining !== 1'b1 || inflight !== 3'd1) begin errors++; $display("FAIL flush_wb1: got draining %b inflight %0d exp 1 1", draining, inflight); end
    wb_rd = 5'd2; flush = 0;
    step();
    idle(); #1;
    checks++; if (draining !== 1'b0 || inflight !== 3'd0 || issue_ready !== 1'b1) begin errors++; $display("FAIL flush_done: got draining %b inflight %0d ready %b exp 0 0 1", draining, inflight, issue_ready); end
    flush = 1; #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_empty_block: got %b exp 0", issue_ready); end
    step();
    flush = 0; #1;
    checks++; if (draining !== 1'b0 || issue_ready !== 1'b1) begin errors++; $display("FAIL flush_empty_run: got draining %b ready %b exp 0 1", draining, issue_ready); end
  endtask

  task automatic test_wb_err();
    wb_valid = 1; wb_rd = 5'd0;
    step();
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL wb_x0_ignored: got %b exp 0", wb_err); end
    wb_rd = 5'd9;
    step();
    idle(); #1;
    checks++; if (wb_err !== 1'b1 || busy_vec !== 32'h0) begin errors++; $display("FAIL wb_err_set: got err %b busy %h exp 1 0", wb_err, busy_vec); end
    step(); step();
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL wb_err_sticky: got %b exp 1", wb_err); end
    issue(5'd10, 1'b1, 5'd0, 1'b0);
    step();
    idle();
    #2 rst_n = 0;
    #1;
    checks++; if (busy_vec !== 32'h0 || inflight !== 3'd0 || draining !== 1'b0 || wb_err !== 1'b0 || stall_cnt !== 16'd0)
      begin errors++; $display("FAIL async_reset: got busy %h inflight %0d drn %b err %b stall %0d exp all 0", busy_vec, inflight, draining, wb_err, stall_cnt); end
    @(negedge clk) rst_n = 1;
    wb_valid = 1; wb_rd = 5'd10;
    step();
    idle(); #1;
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL wb_after_reset: got %b exp 1", wb_err); end
  endtask

  task automatic test_saturate();
    issue(5'd11, 1'b1, 5'd0, 1'b0);
    step();
    issue(5'd0, 1'b0, 5'd11, 1'b1);
    repeat ((1 << 16) + 3) step();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_saturate: got %h exp ffff", stall_cnt); end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_x0();
    test_limit();
    test_flush();
    test_wb_err();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
